// File: rtl/col_nos_addr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// col_nos_addr_sequencer_pkg
//   Shared definitions for the col_nos address sequencer and the col_nos memory.
//   - seq_state_t : sequencer FSM state encoding
//   - calc_address_width : address/count width derived from the index of the
//     last col_nos memory entry (addresses run 0..height inclusive)
// -----------------------------------------------------------------------------
package col_nos_addr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_t;

  function automatic int calc_address_width(input int height);
    return $clog2(height) + 1;
  endfunction

endpackage

// File: rtl/col_nos_addr_sequencer.sv
// -----------------------------------------------------------------------------
// col_nos_addr_sequencer
//   Generates col_nos read addresses base_address .. base_address+num_rows-1
//   for one sparse-matrix pass, qualified by a valid/ready handshake so the
//   row_by_vector consumers can stall. Reports busy/done/range_error status.
//
// Ports
//   clk                  : system clock, rising edge
//   reset                : synchronous active-high reset
//   start                : request a pass (honoured only in IDLE)
//   abort                : terminate the current pass, no done pulse
//   base_address         : first memory row of the pass (sampled on start)
//   num_rows             : rows in the pass (sampled on start)
//   addr_ready           : downstream accepts the current address
//   col_nos_read_address : registered read address to col_nos
//   addr_valid           : col_nos_read_address is meaningful
//   last_row             : final address of the pass (with addr_valid)
//   row_index            : offset of current address from base
//   busy                 : pass in progress (RUN)
//   done                 : one-cycle pulse at pass end
//   range_error          : sticky, start rejected because the pass overruns
// -----------------------------------------------------------------------------
module col_nos_addr_sequencer
  import col_nos_addr_sequencer_pkg::*;
#(
  parameter int memory_A_height = 2000,
  parameter int address_width   = calc_address_width(memory_A_height)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [address_width-1:0] base_address,
  input  logic [address_width-1:0] num_rows,
  input  logic                     addr_ready,
  output logic [address_width-1:0] col_nos_read_address,
  output logic                     addr_valid,
  output logic                     last_row,
  output logic [address_width-1:0] row_index,
  output logic                     busy,
  output logic                     done,
  output logic                     range_error
);

  localparam logic [address_width:0]   LP_MAX_ADDR = (address_width+1)'(memory_A_height);
  localparam logic [address_width:0]   LP_ONE_X    = (address_width+1)'(1);
  localparam logic [address_width-1:0] LP_ONE      = address_width'(1);

  seq_state_t               r_state;
  seq_state_t               w_next_state;
  logic [address_width-1:0] r_addr;
  logic [address_width-1:0] r_row_index;
  logic [address_width-1:0] r_num_rows;
  logic                     r_last_row;
  logic                     r_range_error;

  logic                     w_accept_start;
  logic                     w_zero_rows;
  logic [address_width:0]   w_end_addr;
  logic                     w_range_bad;
  logic                     w_advance;
  logic [address_width-1:0] w_idx_next;

  // The end address is formed one bit wider than the address so that a
  // large base plus a large count cannot wrap and slip past the check.
  assign w_end_addr     = {1'b0, base_address} + {1'b0, num_rows} - LP_ONE_X;
  assign w_zero_rows    = (num_rows == '0);
  assign w_range_bad    = !w_zero_rows && (w_end_addr > LP_MAX_ADDR);
  assign w_accept_start = (r_state == ST_IDLE) && start && !abort;
  assign w_advance      = (r_state == ST_RUN) && !abort && addr_ready && !r_last_row;
  assign w_idx_next     = r_row_index + LP_ONE;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and status outputs
  always_comb begin
    w_next_state = r_state;
    addr_valid   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    last_row     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_start) begin
          if (w_zero_rows || w_range_bad) begin
            w_next_state = ST_FINISH;
          end else begin
            w_next_state = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
        last_row   = r_last_row;
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (addr_ready && r_last_row) begin
          w_next_state = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Address counter and latched pass parameters. The address is only loaded
  // by a start that will actually issue addresses; empty or rejected passes
  // leave the previous address on the bus. A zero-row pass counts as a
  // passing range check and therefore clears range_error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr        <= '0;
      r_row_index   <= '0;
      r_num_rows    <= '0;
      r_last_row    <= 1'b0;
      r_range_error <= 1'b0;
    end else if (w_accept_start) begin
      r_num_rows    <= num_rows;
      r_range_error <= w_range_bad;
      if (!w_zero_rows && !w_range_bad) begin
        r_addr      <= base_address;
        r_row_index <= '0;
        r_last_row  <= (num_rows == LP_ONE);
      end
    end else if (w_advance) begin
      r_addr      <= r_addr + LP_ONE;
      r_row_index <= w_idx_next;
      r_last_row  <= (w_idx_next == (r_num_rows - LP_ONE));
    end
  end

  assign col_nos_read_address = r_addr;
  assign row_index            = r_row_index;
  assign range_error          = r_range_error;

endmodule

// File: tb/tb_col_nos_addr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_col_nos_addr_sequencer
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a queue-based model: an accepted pass becomes a list of expected
//   addresses that drains one entry per accepted handshake.
// -----------------------------------------------------------------------------
module tb_col_nos_addr_sequencer;

  localparam int H  = 2000;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_address;
  logic [AW-1:0] num_rows;
  logic          addr_ready;
  logic [AW-1:0] col_nos_read_address;
  logic          addr_valid;
  logic          last_row;
  logic [AW-1:0] row_index;
  logic          busy;
  logic          done;
  logic          range_error;

  col_nos_addr_sequencer #(.memory_A_height(H)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .abort                (abort),
    .base_address         (base_address),
    .num_rows             (num_rows),
    .addr_ready           (addr_ready),
    .col_nos_read_address (col_nos_read_address),
    .addr_valid           (addr_valid),
    .last_row             (last_row),
    .row_index            (row_index),
    .busy                 (busy),
    .done                 (done),
    .range_error          (range_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  int q[$];          // addresses still to be issued; q[0] is on the bus
  int m_idx;         // offset of q[0] from base
  bit m_fin;         // done pulse expected this cycle
  bit m_err;         // sticky range error
  int sh_addr;       // last address shown on the bus
  int sh_idx;        // last row_index shown

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (q.size() != 0);
    chk("addr_valid",  32'(addr_valid), 32'(v));
    chk("busy",        32'(busy), 32'(v));
    chk("done",        32'(done), 32'(m_fin));
    chk("range_error", 32'(range_error), 32'(m_err));
    chk("last_row",    32'(last_row), 32'(v && q.size() == 1));
    chk("address",     32'(col_nos_read_address), 32'(sh_addr));
    chk("row_index",   32'(row_index), 32'(sh_idx));
  endtask

  task automatic model_update(input bit rst, input bit st, input bit ab, input bit rdy,
                              input int b, input int n);
    if (rst) begin
      q.delete();
      m_fin = 0; m_err = 0; m_idx = 0; sh_addr = 0; sh_idx = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (q.size() > 0) begin
      if (ab) begin
        q.delete();
      end else if (rdy) begin
        void'(q.pop_front());
        m_idx++;
        if (q.size() == 0) m_fin = 1;
      end
    end else if (st && !ab) begin
      if (n == 0) begin
        m_err = 0; m_fin = 1;
      end else if (b + n - 1 > H) begin
        m_err = 1; m_fin = 1;
      end else begin
        m_err = 0; m_idx = 0;
        for (int i = 0; i < n; i++) q.push_back(b + i);
      end
    end
    if (q.size() > 0) begin
      sh_addr = q[0];
      sh_idx  = m_idx;
    end
  endtask

  // One clock: check outputs mid-cycle, drive inputs, then advance the model.
  task automatic step(input bit rst, input bit st, input bit ab, input bit rdy,
                      input int b, input int n);
    @(negedge clk);
    compare_all();
    reset        = rst;
    start        = st;
    abort        = ab;
    addr_ready   = rdy;
    base_address = AW'(b);
    num_rows     = AW'(n);
    @(posedge clk);
    model_update(rst, st, ab, rdy, b, n);
  endtask

  initial begin
    int b, n, mode;
    bit r_rst, r_st, r_ab, r_rdy;
    reset = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    base_address = '0; num_rows = '0;
    repeat (2) @(posedge clk);
    model_update(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Basic pass 10..13
    step(0, 1, 0, 1, 10, 4);
    repeat (6) step(0, 0, 0, 1, 0, 0);

    // Backpressure: address 1 held for three cycles
    step(0, 1, 0, 1, 0, 3);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0, 0);

    // Empty pass, range error, clearing start, boundary pass
    step(0, 1, 0, 1, 5, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 1998, 4);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 1997, 4);
    repeat (6) step(0, 0, 0, 1, 0, 0);

    // Abort at row_index 2, start during RUN ignored, abort+start in IDLE
    step(0, 1, 0, 1, 100, 10);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 50, 2);
    step(0, 1, 0, 1, 200, 5);
    step(0, 1, 0, 1, 7, 3);
    repeat (6) step(0, 0, 0, 1, 0, 0);

    // Reset at row_index 5, then a fresh pass
    step(0, 1, 0, 1, 300, 10);
    repeat (5) step(0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 40, 2);
    repeat (4) step(0, 0, 0, 1, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_ab  = ($urandom_range(0, 39) == 0);
      r_st  = ($urandom_range(0, 5) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      mode  = $urandom_range(0, 7);
      case (mode)
        0:       begin b = $urandom_range(0, H);       n = 0;                      end
        1:       begin b = $urandom_range(1985, H);    n = $urandom_range(1, 16);  end
        2:       begin b = $urandom_range(0, 4095);    n = $urandom_range(1, 4095); end
        default: begin b = $urandom_range(0, H);       n = $urandom_range(1, 24);  end
      endcase
      step(r_rst, r_st, r_ab, r_rdy, b, n);
    end
    @(negedge clk);
    compare_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/col_nos_addr_sequencer.md
Name: col_nos_addr_sequencer

Overview:
- Upstream stage of the col_nos memory. Generates the sequence of col_nos_read_address values for one sparse-matrix pass, from base_address through base_address+num_rows-1.
- Qualifies each address with a valid/ready handshake so the downstream row_by_vector modules can stall.
- The col_nos read is combinational, so the col_nos_output word belongs to the same cycle in which addr_valid && addr_ready.
- Reports busy, done and range-error status to the solver controller.

Parameters:
- memory_A_height, 2000, index of the last col_nos memory entry (valid addresses are 0..memory_A_height).
- address_width, $clog2(memory_A_height)+1, width of every address/count signal.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a pass; honoured only in IDLE.
- abort  input  1  terminates the current pass; return to IDLE, no done pulse.
- base_address  input  address_width  first memory row of the pass; sampled on accepted start.
- num_rows  input  address_width  rows in the pass; sampled on accepted start.
- addr_ready  input  1  downstream accepts the current address this cycle.
- col_nos_read_address  output  address_width  registered read address to col_nos.
- addr_valid  output  1  col_nos_read_address is meaningful.
- last_row  output  1  high with addr_valid on the final address of the pass.
- row_index  output  address_width  offset of the current address from base (0..num_rows-1).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at pass end.
- range_error  output  1  sticky; set when a start is rejected for range.

Behaviour:
- Reset: state=IDLE. All outputs 0: col_nos_read_address, addr_valid, last_row, row_index, busy, done, range_error.
- States:
  - IDLE.
  - RUN.
  - FINISH: one cycle, done=1.
- IDLE + start:
  - Latch base and num_rows.
  - num_rows==0 -> FINISH next cycle. No addresses are issued.
  - base+num_rows-1 > memory_A_height -> set range_error, go to FINISH. No addresses are issued. Compute the sum at address_width+1 bits to avoid wrap.
  - Otherwise -> RUN next cycle with col_nos_read_address=base, row_index=0, addr_valid=1, last_row=(num_rows==1).
  - Latency from start to first valid address: 1 cycle.
- RUN, addr_valid && addr_ready && !last_row:
  - Next cycle: address+1, row_index+1.
  - last_row asserted when row_index==num_rows-1.
- RUN, addr_valid && !addr_ready:
  - Hold address, row_index and last_row stable.
  - addr_valid stays high (no retraction).
- RUN, last_row && addr_ready -> FINISH. addr_valid=0 and busy=0 next cycle.
- FINISH: done=1 for exactly one cycle, then IDLE. A start in FINISH is ignored.
- start in RUN or FINISH: ignored, no effect on latched values.
- abort:
  - In RUN -> IDLE next cycle. addr_valid=0, no done.
  - abort and start in the same IDLE cycle: abort wins, start ignored.
  - In FINISH, abort has no effect; done still pulses.
- range_error: cleared only by reset or by the next accepted start that passes the range check.
- Throughput: one address per cycle with addr_ready held high. A pass of N rows takes N cycles in RUN, plus 1 cycle FINISH.
- Reset mid-pass: the synchronous reset wins over all other inputs that cycle, and all outputs take their reset values next edge.
- Width: internal counters are address_width bits. The range check guarantees no address wrap.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, FINISH=2'd2);
  - the address_width derivation function shared with the col_nos memory.
- No sub-module. Single FSM plus one counter; RTL estimate ~150 lines.

Test Plan:
- Basic pass:
  - Stimulus: base=10, num_rows=4, addr_ready=1.
  - Response: addresses 10,11,12,13 on consecutive cycles starting 1 cycle after start; last_row only at 13; done pulse the cycle after 13; busy high for 4 cycles.
- Backpressure:
  - Stimulus: base=0, num_rows=3, addr_ready low for 2 cycles while address=1.
  - Response: address 1 held with addr_valid=1 for 3 cycles; total 5 RUN cycles; sequence 0,1,1,1,2.
- Degenerate and range cases:
  - num_rows=0 -> no addr_valid, done 1 cycle after start, range_error=0.
  - base=1998, num_rows=4 -> range_error=1, no addr_valid, done pulses.
  - A subsequent valid start clears range_error.
- Boundary:
  - Stimulus: base=1997, num_rows=4.
  - Response: addresses 1997..2000 issued; last_row at 2000; no error.
- Abort and ignored start:
  - Stimulus: abort at row_index=2 of a 10-row pass.
  - Response: IDLE next cycle, addr_valid=0, no done. A start pulsed during RUN of another pass does not restart it.
- Reset mid-pass:
  - Stimulus: reset at row_index=5.
  - Response: next edge all outputs 0; the following start behaves as a fresh pass.
